mux_arb_n: RTL and testbench

- Parametrised N-input, W-bit multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes: a fixed channel chosen by an external select, or round-robin arbitration over requesting channels.
- Output is registered through one stage. Used wherever several producers share one downstream consumer.

---
 rtl/mux_arb_pkg.sv | 36 +++
 rtl/mux_arb_n_rr.sv | 53 +++++
 rtl/mux_arb_n.sv | 126 ++++++++++++
 tb/tb_mux_arb_n.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N-input mux/arbiter.
// Mode encodings and a reusable rotate-priority pick.
package mux_arb_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int RR_MAXN = 16;
  localparam int RR_IDXW = 4;

  // Scan ptr, ptr+1, ..., n-1, 0, ..., ptr-1; return {found, index}.
  function automatic logic [RR_IDXW:0] rr_pick(
    input logic [RR_MAXN-1:0] valid,
    input logic [RR_IDXW-1:0] ptr,
    input logic [RR_IDXW:0]   n
  );
    logic               found;
    logic [RR_IDXW-1:0] idx;
    logic [RR_IDXW:0]   c;
    found = 1'b0;
    idx   = '0;
    c     = '0;
    for (int k = 0; k < RR_MAXN; k++) begin
      if (k < int'(n) && !found) begin
        c = {1'b0, ptr} + 5'(k);
        if (c >= n) c = c - n;
        if (valid[c[RR_IDXW-1:0]]) begin
          found = 1'b1;
          idx   = c[RR_IDXW-1:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux_arb_n_rr.sv
// Round-robin arbiter: rotating pointer plus
// rotate-priority pick over the request vector.
module rr_arbiter_n
  import mux_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    valid_i,
  input  logic            advance_i,
  output logic [SELW-1:0] grant_o,
  output logic            grant_valid_o
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [SELW-1:0]    ptr_q;
  logic [SELW-1:0]    ptr_d;
  logic [RR_MAXN-1:0] vpad;
  logic [RR_IDXW-1:0] ppad;
  logic [RR_IDXW:0]   pick;
  logic               unused_pick;

  // Widen request and pointer to the pick function's fixed size.
  always_comb begin
    vpad = '0;
    vpad[N-1:0] = valid_i;
    ppad = '0;
    ppad[SELW-1:0] = ptr_q;
    pick = rr_pick(vpad, ppad, 5'(N));
  end

  assign grant_o       = pick[SELW-1:0];
  assign grant_valid_o = pick[RR_IDXW];
  assign unused_pick   = ^pick[RR_IDXW-1:0];

  // Pointer moves just past the granted channel on each advance.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_o == LAST) ? '0 : grant_o + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-input W-bit mux with valid/ready on each side,
// select-driven or round-robin, one registered output stage.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  input  logic            out_ready
);

  logic [SELW-1:0]       rr_grant;
  logic                  rr_gv;
  logic                  rr_adv;
  logic                  sel_ok;
  logic [(1<<SELW)-1:0]  vsel;
  logic [SELW-1:0]       grant;
  logic                  grant_valid;
  logic                  load;
  logic                  xfer;
  logic [W-1:0]          gdata;

  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          out_data_q, out_data_d;
  logic [SELW-1:0]       out_ch_q, out_ch_d;

  rr_arbiter_n #(
    .N    (N),
    .SELW (SELW)
  ) u_rr (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (in_valid),
    .advance_i     (rr_adv),
    .grant_o       (rr_grant),
    .grant_valid_o (rr_gv)
  );

  if ((1 << SELW) == N) begin : g_pow2
    assign sel_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [SELW-1:0] NLIM = SELW'(N);
    assign sel_ok = (sel < NLIM);
  end

  // Pad requests so any sel value indexes safely.
  always_comb begin
    vsel = '0;
    vsel[N-1:0] = in_valid;
  end

  // Grant source follows the current mode.
  always_comb begin
    grant       = sel;
    grant_valid = 1'b0;
    unique case (1'b1)
      (mode == MODE_RR): begin
        grant       = rr_grant;
        grant_valid = rr_gv;
      end
      default: begin
        grant       = sel;
        grant_valid = sel_ok && vsel[sel];
      end
    endcase
  end

  assign load   = !out_valid_q || out_ready;
  assign xfer   = load && grant_valid && !rst;
  assign rr_adv = xfer && (mode == MODE_RR);

  // One-hot accept and data select for the granted channel.
  always_comb begin
    in_ready = '0;
    gdata    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        in_ready[i] = xfer;
        gdata       = in_data[i*W +: W];
      end
    end
  end

  // Output stage: load on transfer, empty when drained idle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = gdata;
        out_ch_d   = grant;
      end
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n (N=4, W=8): vector table
// with a one-deep expected-output queue, plus reset sequence.
module tb_mux_arb_n;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         mode;
  logic [1:0]   sel;
  logic [3:0]   in_valid;
  logic [31:0]  in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_ch;
  logic         out_ready;

  mux_arb_n #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [1:0]  s;
    logic [3:0]  iv;
    logic        ordy;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  ch;
  } vec_t;

  typedef struct packed {
    logic       ov;
    logic [7:0] od;
    logic [1:0] ch;
  } exp_t;

  localparam logic [31:0] D = 32'h13121110;

  vec_t tv[29];
  exp_t sbq[$];
  int   n_chk;
  int   n_fail;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    mode      = v.m;
    sel       = v.s;
    in_valid  = v.iv;
    out_ready = v.ordy;
    in_data   = v.d;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
    sbq.push_back('{v.ov, v.od, v.ch});
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, ".queue"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
      chk({tag, ".out_data"}, 32'(out_data), 32'(e.od));
      chk({tag, ".out_ch"}, 32'(out_ch), 32'(e.ch));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    //          m     s     iv       rdy  d               rdy      ov    od     ch
    tv[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 32'h133C1110, 4'b0100, 1'b1, 8'h3C, 2'd2};
    tv[1]  = '{1'b0, 2'd1, 4'b0100, 1'b1, 32'h133C1110, 4'b0000, 1'b0, 8'h3C, 2'd2};
    tv[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b0001, 1'b1, 8'h10, 2'd0};
    tv[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b0010, 1'b1, 8'h11, 2'd1};
    tv[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b0100, 1'b1, 8'h12, 2'd2};
    tv[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b1000, 1'b1, 8'h13, 2'd3};
    tv[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b0001, 1'b1, 8'h10, 2'd0};
    tv[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b0010, 1'b1, 8'h11, 2'd1};
    tv[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b0100, 1'b1, 8'h12, 2'd2};
    tv[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b1000, 1'b1, 8'h13, 2'd3};
    tv[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, D,            4'b0010, 1'b1, 8'h11, 2'd1};
    tv[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, D,            4'b1000, 1'b1, 8'h13, 2'd3};
    tv[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, D,            4'b0010, 1'b1, 8'h11, 2'd1};
    tv[13] = '{1'b1, 2'd0, 4'b0010, 1'b1, D,            4'b0010, 1'b1, 8'h11, 2'd1};
    tv[14] = '{1'b1, 2'd0, 4'b0100, 1'b1, 32'h13771110, 4'b0100, 1'b1, 8'h77, 2'd2};
    tv[15] = '{1'b1, 2'd0, 4'b1111, 1'b0, D,            4'b0000, 1'b1, 8'h77, 2'd2};
    tv[16] = '{1'b1, 2'd0, 4'b1111, 1'b0, D,            4'b0000, 1'b1, 8'h77, 2'd2};
    tv[17] = '{1'b1, 2'd0, 4'b1111, 1'b0, D,            4'b0000, 1'b1, 8'h77, 2'd2};
    tv[18] = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b1000, 1'b1, 8'h13, 2'd3};
    tv[19] = '{1'b1, 2'd0, 4'b0100, 1'b1, D,            4'b0100, 1'b1, 8'h12, 2'd2};
    tv[20] = '{1'b0, 2'd0, 4'b0001, 1'b1, D,            4'b0001, 1'b1, 8'h10, 2'd0};
    tv[21] = '{1'b0, 2'd0, 4'b0001, 1'b1, D,            4'b0001, 1'b1, 8'h10, 2'd0};
    tv[22] = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b1000, 1'b1, 8'h13, 2'd3};
    tv[23] = '{1'b1, 2'd0, 4'b0000, 1'b0, D,            4'b0000, 1'b1, 8'h13, 2'd3};
    tv[24] = '{1'b1, 2'd0, 4'b0000, 1'b1, D,            4'b0000, 1'b0, 8'h13, 2'd3};
    tv[25] = '{1'b1, 2'd0, 4'b0010, 1'b1, D,            4'b0010, 1'b1, 8'h11, 2'd1};
    tv[26] = '{1'b0, 2'd1, 4'b0010, 1'b1, 32'h1312A510, 4'b0010, 1'b1, 8'hA5, 2'd1};
    tv[27] = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b0001, 1'b1, 8'h10, 2'd0};
    tv[28] = '{1'b1, 2'd0, 4'b1111, 1'b1, D,            4'b0010, 1'b1, 8'h11, 2'd1};

    rst       = 1'b1;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    in_data   = D;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.out_data", 32'(out_data), 0);
    chk("reset.out_ch", 32'(out_ch), 0);
    chk("reset.in_ready", 32'(in_ready), 0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      apply(tv[i], $sformatf("row%0d", i));
    end

    in_valid  = 4'b0000;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.out_data", 32'(out_data), 0);
    chk("midrst.out_ch", 32'(out_ch), 0);
    chk("midrst.in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    apply(tv[27], "postrst0");
    apply(tv[28], "postrst1");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
